// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    // Controller FSM encoding, exported on the state port
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MEMWAIT = 2'b01,
        ST_FAULT   = 2'b10
    } state_t;

    // resultSrc value that marks a load in Execute
    localparam logic [1:0] RES_LOAD = 2'b01;

    // ALU operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_forward_sel.sv
// Picks the bypass source for one ALU operand; MEM beats WB, x0 never forwards.
// Latency: purely combinational.
// Backpressure: none, independent of controller state.
module forward_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_mem,
    input  logic       wr_mem,
    input  logic [4:0] rd_wb,
    input  logic       wr_wb,
    output logic [1:0] sel
);

    // Priority select: youngest producer (MEM) first, then WB, else register file
    always_comb begin
        sel = FWD_RF;
        if (wr_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
            sel = FWD_MEM;
        end else if (wr_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use stall, branch flush, memory-wait stall with timeout.
// Latency: stall/flush/forward outputs are combinational; state and counters update on the next edge.
// Backpressure: a memory wait freezes all four pipeline registers until ready, or forever once FAULT.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       resultSrcE,
    input  logic             pcSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic             memReqM,
    input  logic             memReadyM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             fault,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                mem_wait, load_use;
    logic                stall_all, stall_fd, flush_d, flush_e;
    logic                run_flush_d, run_flush_e, run_stall_fd;

    forward_sel u_fwd_a (
        .rs     (Rs1E),
        .rd_mem (RdM),
        .wr_mem (regWriteM),
        .rd_wb  (RdW),
        .wr_wb  (regWriteW),
        .sel    (forwardAE)
    );

    forward_sel u_fwd_b (
        .rs     (Rs2E),
        .rd_mem (RdM),
        .wr_mem (regWriteM),
        .rd_wb  (RdW),
        .wr_wb  (regWriteW),
        .sel    (forwardBE)
    );

    assign mem_wait = memReqM && !memReadyM;
    assign load_use = (resultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // Normal-flow response: a taken branch squashes the load-use bubble
    assign run_flush_d  = pcSrcE;
    assign run_flush_e  = pcSrcE || load_use;
    assign run_stall_fd = !pcSrcE && load_use;

    // Next state and raw stall/flush decisions for the current state
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        stall_all = 1'b0;
        stall_fd  = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    stall_all = 1'b1;
                    state_d   = ST_MEMWAIT;
                    wcnt_d    = WCNT_W'(1);
                end else begin
                    stall_fd = run_stall_fd;
                    flush_d  = run_flush_d;
                    flush_e  = run_flush_e;
                end
            end
            ST_MEMWAIT: begin
                if (!memReadyM) begin
                    stall_all = 1'b1;
                    // Counter holds the cycles already spent waiting
                    if (wcnt_q >= WCNT_W'(WAIT_LIMIT)) begin
                        state_d = ST_FAULT;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end else begin
                    stall_fd = run_stall_fd;
                    flush_d  = run_flush_d;
                    flush_e  = run_flush_e;
                    state_d  = ST_RUN;
                    wcnt_d   = '0;
                end
            end
            ST_FAULT: begin
                stall_all = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // Reset masks everything so a wait or fault leaves no residual stall
    assign stallF = !rst && (stall_all || stall_fd);
    assign stallD = !rst && (stall_all || stall_fd);
    assign stallE = !rst && stall_all;
    assign stallM = !rst && stall_all;
    assign flushD = !rst && flush_d;
    assign flushE = !rst && flush_e;
    assign fault  = !rst && (state_q == ST_FAULT);
    assign state  = state_q;

    // State, wait counter and saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            wcnt_q   <= '0;
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (stallF && (stallCnt != {CNT_W{1'b1}})) begin
                stallCnt <= stallCnt + 1'b1;
            end
            if (flushE && (flushCnt != {CNT_W{1'b1}})) begin
                flushCnt <= flushCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short wait limit and narrow counters.
// Latency: n/a.
// Backpressure: n/a.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] resultSrcE;
    logic       pcSrcE, regWriteM, regWriteW, memReqM, memReadyM;
    logic       stallF, stallD, stallE, stallM, flushD, flushE, fault;
    logic [1:0] forwardAE, forwardBE, state;
    logic [3:0] stallCnt, flushCnt;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.WAIT_LIMIT(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .resultSrcE (resultSrcE),
        .pcSrcE     (pcSrcE),
        .RdM        (RdM),
        .RdW        (RdW),
        .regWriteM  (regWriteM),
        .regWriteW  (regWriteW),
        .memReqM    (memReqM),
        .memReadyM  (memReadyM),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .stallM     (stallM),
        .flushD     (flushD),
        .flushE     (flushE),
        .forwardAE  (forwardAE),
        .forwardBE  (forwardBE),
        .fault      (fault),
        .state      (state),
        .stallCnt   (stallCnt),
        .flushCnt   (flushCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs may be changed right after return
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change
    task automatic settle();
        #1;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        resultSrcE = 2'b00; pcSrcE = 0; regWriteM = 0; regWriteW = 0;
        memReqM = 0; memReadyM = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // {stallF,stallD,stallE,stallM,flushD,flushE}
    function automatic logic [5:0] ctl();
        return {stallF, stallD, stallE, stallM, flushD, flushE};
    endfunction

    initial begin
        idle();
        rst = 1;
        // Reset masks even a taken branch
        pcSrcE = 1;
        settle();
        chk("rst_mask_ctl", 32'(ctl()), 32'b000000);
        tick();
        tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_stallcnt", 32'(stallCnt), 0);
        chk("rst_flushcnt", 32'(flushCnt), 0);
        rst = 0;
        idle();
        settle();
        chk("idle_ctl", 32'(ctl()), 32'b000000);

        // Forwarding, pure combinational
        RdM = 5; regWriteM = 1; RdW = 5; regWriteW = 1; Rs1E = 5;
        settle();
        chk("fwdA_mem", 32'(forwardAE), 32'b10);
        chk("fwdB_none", 32'(forwardBE), 32'b00);
        RdM = 0;
        settle();
        chk("fwdA_wb", 32'(forwardAE), 32'b01);
        Rs2E = 9; RdW = 9; RdM = 9; regWriteM = 0;
        settle();
        chk("fwdB_wb_memoff", 32'(forwardBE), 32'b01);
        chk("fwdA_none", 32'(forwardAE), 32'b00);
        regWriteM = 1;
        settle();
        chk("fwdB_mem", 32'(forwardBE), 32'b10);
        Rs1E = 0; RdW = 0; RdM = 0;
        settle();
        chk("fwd_x0", 32'(forwardAE), 32'b00);
        idle();

        // Load-use bubble
        resultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        settle();
        chk("lu_ctl", 32'(ctl()), 32'b110001);
        tick();
        idle();
        settle();
        chk("lu_one_cycle", 32'(ctl()), 32'b000000);
        chk("lu_stallcnt", 32'(stallCnt), 1);
        chk("lu_flushcnt", 32'(flushCnt), 1);

        // Load-use with a taken branch: branch wins
        resultSrcE = 2'b01; RdE = 7; Rs2D = 7; pcSrcE = 1;
        settle();
        chk("lu_br_ctl", 32'(ctl()), 32'b000011);
        tick();
        idle();
        chk("lu_br_stallcnt", 32'(stallCnt), 1);
        chk("lu_br_flushcnt", 32'(flushCnt), 2);

        // Load to x0 is not a hazard
        resultSrcE = 2'b01; RdE = 0; Rs1D = 0;
        settle();
        chk("lu_x0", 32'(ctl()), 32'b000000);
        // Non-load in Execute is not a hazard either
        resultSrcE = 2'b10; RdE = 3; Rs1D = 3;
        settle();
        chk("lu_nonload", 32'(ctl()), 32'b000000);
        idle();

        // Memory wait of three cycles then ready
        do_reset();
        memReqM = 1; memReadyM = 0; pcSrcE = 1;
        settle();
        chk("mw0_ctl", 32'(ctl()), 32'b111100);
        tick();
        chk("mw0_state", 32'(state), 32'b01);
        resultSrcE = 2'b01; RdE = 4; Rs1D = 4;
        settle();
        chk("mw1_ctl", 32'(ctl()), 32'b111100);
        tick();
        pcSrcE = 0; resultSrcE = 2'b00;
        settle();
        chk("mw2_ctl", 32'(ctl()), 32'b111100);
        tick();
        chk("mw2_state", 32'(state), 32'b01);
        memReadyM = 1;
        settle();
        chk("mw_rdy_ctl", 32'(ctl()), 32'b000000);
        tick();
        idle();
        chk("mw_done_state", 32'(state), 32'b00);
        chk("mw_stallcnt", 32'(stallCnt), 3);
        chk("mw_flushcnt", 32'(flushCnt), 0);

        // Ready arrives together with a load-use hazard
        memReqM = 1; memReadyM = 0;
        tick();
        memReadyM = 1; resultSrcE = 2'b01; RdE = 6; Rs1D = 6;
        settle();
        chk("mw_rdy_lu_ctl", 32'(ctl()), 32'b110001);
        tick();
        idle();
        chk("mw_rdy_lu_state", 32'(state), 32'b00);

        // Flush counter saturation
        do_reset();
        pcSrcE = 1;
        for (int i = 0; i < 15; i++) tick();
        chk("flushcnt_full", 32'(flushCnt), 15);
        tick();
        tick();
        chk("flushcnt_sat", 32'(flushCnt), 15);
        idle();

        // Wait timeout into FAULT
        do_reset();
        memReqM = 1; memReadyM = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("to_pre_state", 32'(state), 32'b01);
        chk("to_pre_fault", 32'(fault), 0);
        tick();
        chk("to_state", 32'(state), 32'b10);
        chk("to_fault", 32'(fault), 1);
        // Inputs ignored in FAULT
        memReadyM = 1; memReqM = 0; pcSrcE = 1;
        resultSrcE = 2'b01; RdE = 2; Rs2D = 2;
        settle();
        chk("flt_ctl", 32'(ctl()), 32'b111100);
        for (int i = 0; i < 12; i++) tick();
        chk("flt_hold_state", 32'(state), 32'b10);
        chk("flt_hold_fault", 32'(fault), 1);
        chk("stallcnt_sat", 32'(stallCnt), 15);
        chk("flt_flushcnt", 32'(flushCnt), 0);
        rst = 1;
        settle();
        chk("flt_rst_ctl", 32'(ctl()), 32'b000000);
        chk("flt_rst_fault", 32'(fault), 0);
        tick();
        rst = 0;
        idle();
        settle();
        chk("post_rst_state", 32'(state), 32'b00);
        chk("post_rst_ctl", 32'(ctl()), 32'b000000);
        chk("post_rst_stallcnt", 32'(stallCnt), 0);
        chk("post_rst_flushcnt", 32'(flushCnt), 0);
        tick();
        chk("post_rst_run", 32'(state), 32'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 255: memory-wait cycles tolerated before FAULT.
REQ-002 Parameter CNT_W, default 16: width of performance counters.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 Rs1D, Rs2D  in  5  source registers of instruction in Decode.
REQ-006 Rs1E, Rs2E, RdE  in  5  source and destination registers in Execute.
REQ-007 resultSrcE  in  2  result source in Execute; 2'b01 = load.
REQ-008 pcSrcE  in  1  taken branch or jump resolved in Execute.
REQ-009 RdM, RdW  in  5  destination registers in Memory and Writeback.
REQ-010 regWriteM, regWriteW  in  1  register-write enables in Memory and Writeback.
REQ-011 memReqM, memReadyM  in  1  data-memory request in Memory and its ready response.
REQ-012 stallF, stallD, stallE, stallM  out  1  hold corresponding pipeline register.
REQ-013 flushD, flushE  out  1  clear IF/ID and ID/EX registers (drives clr).
REQ-014 forwardAE, forwardBE  out  2  ALU operand select: 00 register file, 01 WB, 10 MEM.
REQ-015 fault  out  1  memory-wait timeout flag.
REQ-016 state  out  2  FSM state: RUN 00, MEMWAIT 01, FAULT 10.
REQ-017 stallCnt, flushCnt  out  CNT_W  saturating counts of stall and flush cycles.

Function
REQ-018 forwardAE SHALL be 10 when regWriteM && RdM!=0 && RdM==Rs1E, else 01 when regWriteW && RdW!=0 && RdW==Rs1E, else 00; forwardBE identical using Rs2E; MEM has priority.
REQ-019 Forwarding SHALL be combinational and independent of FSM state.
REQ-020 memWait = memReqM && !memReadyM; loadUse = resultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
REQ-021 In RUN with memWait: stallF/D/E/M=1, flushD=flushE=0 same cycle; next state MEMWAIT, wait counter loaded with 1.
REQ-022 In RUN without memWait and pcSrcE=1: flushD=flushE=1, no stalls; this holds even if loadUse=1.
REQ-023 In RUN without memWait, pcSrcE=0, loadUse=1: stallF=stallD=1, flushE=1, stallE=stallM=0 for exactly that cycle.
REQ-024 In MEMWAIT with memReadyM=0: all four stalls=1, no flush; wait counter increments; pcSrcE and loadUse ignored.
REQ-025 In MEMWAIT with memReadyM=1: outputs evaluated as in RUN (REQ-022/023) that cycle; next state RUN.
REQ-026 In MEMWAIT, when wait counter reaches WAIT_LIMIT with memReadyM=0: next state FAULT.
REQ-027 In FAULT: fault=1, all stalls=1, flushes=0, all inputs ignored, state held until rst.
REQ-028 stallCnt SHALL increment on every cycle with stallF=1; flushCnt on every cycle with flushE=1; both saturate at all-ones, no wrap.

Reset
REQ-029 On rst: state=RUN, wait counter=0, stallCnt=0, flushCnt=0, fault=0.
REQ-030 While rst=1, stall and flush outputs SHALL be 0; rst in MEMWAIT or FAULT SHALL abandon the wait with no residual stall next cycle.

Structure
REQ-031 Shared package SHALL hold the state encoding, the load resultSrc encoding 2'b01, and forward-select encodings.
REQ-032 Forwarding logic SHALL be one sub-module forward_sel, instantiated twice (A and B operand).

Verification
REQ-033 RdM=5, regWriteM=1, RdW=5, regWriteW=1, Rs1E=5 -> forwardAE=10; with RdM=0 -> forwardAE=01.
REQ-034 resultSrcE=01, RdE=7, Rs2D=7 in RUN -> one cycle stallF=stallD=flushE=1, stallCnt 0->1, flushCnt 0->1.
REQ-035 Same as REQ-034 plus pcSrcE=1 -> flushD=flushE=1, stallF=0.
REQ-036 memReqM=1, memReadyM=0 for 3 cycles then 1 -> stalls high 3 cycles, state 01 then 00, stallCnt=3.
REQ-037 memReadyM held 0 with WAIT_LIMIT=4 -> state=10, fault=1 persists; rst pulse -> state=00, fault=0, counters 0.
